// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and FSM encoding for the memory-mapped down-counting timer.
// Rev 1.0
`default_nettype none

package timer_pkg;

    localparam logic [1:0] c_add_ctrl     = 2'd0;
    localparam logic [1:0] c_add_preset   = 2'd1;
    localparam logic [1:0] c_add_count    = 2'd2;
    localparam logic [1:0] c_add_prescale = 2'd3;

    localparam int c_ctrl_en       = 0;
    localparam int c_ctrl_mode_lsb = 1;
    localparam int c_ctrl_mode_msb = 2;
    localparam int c_ctrl_im       = 3;

    localparam logic [1:0] c_mode_oneshot = 2'b00;
    localparam logic [1:0] c_mode_reload  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

`default_nettype wire

// File: rtl/timer_if.sv
// timer_if: bridge-side register bus of one timer instance (word select, strobe, data, IRQ).
// Rev 1.0
`default_nettype none

interface timer_if;
    logic [1:0]  ADD;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    modport master (output ADD, WE, DIN, input DOUT, IRQ);
    modport slave  (input ADD, WE, DIN, output DOUT, IRQ);
endinterface

`default_nettype wire

// File: rtl/timer_prescaler.sv
// timer_prescaler: tick divider, one tick every PRESCALE+1 clocks; restart zeroes the divider.
// Rev 1.0
`default_nettype none

module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  restart,
    input  wire logic [PRESCALE_W-1:0] prescale,
    output wire logic                  tick
);

    logic [PRESCALE_W-1:0] r_div;

    assign tick = (r_div == prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (restart || tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_dev.sv
// timer_dev: 32-bit down-counting timer with CTRL/PRESET/COUNT registers, one-shot/auto-reload and IRQ.
// Optional PRESCALE register and tick divider under macro TIMER_PRESCALER_EN. Rev 1.0
`default_nettype none

module timer_dev
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    timer_if.slave    bus
);

    logic [3:0]   r_ctrl;
    logic [31:0]  r_preset;
    logic [31:0]  r_count;
    logic         r_pend;
    logic         r_pulse;
    timer_state_e r_state;
    timer_state_e w_state_nxt;

    logic w_tick, w_load, w_dec, w_expire, w_fire, w_reload;
    logic w_wr_ctrl, w_wr_preset;
    logic [31:0] w_prescale_rd;

    if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_bad_prescale_w
        $error("timer_dev: PRESCALE_W must be 1..32");
    end

    assign w_wr_ctrl   = bus.WE && (bus.ADD == c_add_ctrl);
    assign w_wr_preset = bus.WE && (bus.ADD == c_add_preset);
    assign w_reload    = (r_ctrl[c_ctrl_mode_msb:c_ctrl_mode_lsb] == c_mode_reload);

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  w_wr_prescale;

    assign w_wr_prescale = bus.WE && (bus.ADD == c_add_prescale);
    assign w_prescale_rd = 32'(r_prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            r_prescale <= bus.DIN[PRESCALE_W-1:0];
        end
    end

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_wr_prescale || (w_state_nxt == ST_LOAD && r_state != ST_LOAD)),
        .prescale (r_prescale),
        .tick     (w_tick)
    );
`else
    assign w_tick        = 1'b1;
    assign w_prescale_rd = 32'd0;
`endif

    // EN low overrides everything, independent of the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_expire    = 1'b0;
        w_fire      = 1'b0;
        if (!r_ctrl[c_ctrl_en]) begin
            w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
            unique case (r_state)
                ST_IDLE: w_state_nxt = ST_LOAD;
                ST_LOAD: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CNT;
                end
                ST_CNT: begin
                    if (r_count > 32'd1) begin
                        w_dec = 1'b1;
                    end else begin
                        w_expire    = 1'b1;
                        w_state_nxt = ST_INT;
                    end
                end
                ST_INT: begin
                    w_fire      = 1'b1;
                    w_state_nxt = w_reload ? ST_LOAD : ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_preset <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - 32'd1;
            end else if (w_expire) begin
                r_count <= '0;
            end
            if (w_wr_preset) begin
                r_preset <= bus.DIN;
            end
        end
    end

    // A CPU CTRL write wins over the FSM: it keeps its EN value and suppresses irq_pend.
    // r_pulse marks an auto-reload pend so it drops after exactly one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl  <= '0;
            r_pend  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_fire && w_reload && !w_wr_ctrl;
            if (w_wr_ctrl) begin
                r_ctrl <= bus.DIN[3:0];
                r_pend <= 1'b0;
            end else if (w_fire) begin
                r_pend <= 1'b1;
                if (!w_reload) begin
                    r_ctrl[c_ctrl_en] <= 1'b0;
                end
            end else if (r_pulse) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.DOUT = 32'd0;
        unique case (bus.ADD)
            c_add_ctrl:     bus.DOUT = {28'd0, r_ctrl};
            c_add_preset:   bus.DOUT = r_preset;
            c_add_count:    bus.DOUT = r_count;
            c_add_prescale: bus.DOUT = w_prescale_rd;
            default:        bus.DOUT = 32'd0;
        endcase
    end

    assign bus.IRQ = r_ctrl[c_ctrl_im] & r_pend;

endmodule

`default_nettype wire
